// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Instruction layout: [11:8] opcode, [7:4] operand A, [3:0] operand B
  localparam int INSTR_W = 12;
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int OPA_MSB = 7;
  localparam int OPA_LSB = 4;
  localparam int OPB_MSB = 3;
  localparam int OPB_LSB = 0;

  // Opcode that stops fetching once it has been issued downstream
  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // Extract the opcode field of an instruction word
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction slot handed from fetch to execute (valid/ready).
// Latency: n/a (wiring only).
// Backpressure: slot holds while out_valid && !out_ready.
interface instr_fetch_unit_if #(
  parameter int PC_W = 4
);
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      opcode;
  logic [3:0]      operand_a;
  logic [3:0]      operand_b;
  logic [PC_W-1:0] out_pc;

  // Fetch side drives the slot, execute side returns ready
  modport master (
    output out_valid, opcode, operand_a, operand_b, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, opcode, operand_a, operand_b, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_imem.sv
// Small program memory: one synchronous write port, one combinational read port.
// Latency: read is combinational; a write is visible after the next rising edge.
// Backpressure: none; contents are deliberately not reset.
module fetch_imem #(
  parameter int AW = 4,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write port: program loading
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program memory + PC, presents one instruction slot downstream; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: start at edge k -> instruction 0 valid after edge k+1; redirect -> refetched instruction one cycle after the flush.
// Backpressure: slot and PC hold while out_valid && !out_ready; 1 instr/cycle with ready held high.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int         PC_W        = 4,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  instr_fetch_unit_if.master slot,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [7:0]         fetch_count,
  output logic [7:0]         stall_count
`endif
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic               halted_q, halted_d;

  logic [INSTR_W-1:0] mem_rdata;
  logic               stopped;
  logic               mem_we;
  logic               start_ok;
  logic               xfer;
  logic               stall;

  // Program loading and (re)start are only legal while the fetch loop is parked
  assign stopped  = (state_q == IDLE) || (state_q == HALTED);
  assign mem_we   = prog_we && stopped;
  assign start_ok = start && stopped;
  assign xfer     = vld_q && slot.out_ready;
  assign stall    = vld_q && !slot.out_ready;

  fetch_imem #(
    .AW (PC_W),
    .DW (INSTR_W)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  // State, PC and output slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      vld_q    <= 1'b0;
      instr_q  <= '0;
      out_pc_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      halted_q <= halted_d;
    end
  end

  // Next-state: start, fetch/load, halt drain and redirect flush
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    instr_d  = instr_q;
    out_pc_d = out_pc_q;
    halted_d = halted_q;

    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // A flush beats the next load; a transfer in the same cycle still completes
        if (redirect) begin
          vld_d = 1'b0;
          pc_d  = redirect_pc;
        end else if (!vld_q || xfer) begin
          vld_d    = 1'b1;
          instr_d  = mem_rdata;
          out_pc_d = pc_q;
          if (opcode_of(mem_rdata) == HALT_OPCODE) begin
            // Halt is still issued; PC parks on it and no more fetches happen
            state_d = DRAIN;
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
      end

      DRAIN: begin
        if (redirect) begin
          vld_d   = 1'b0;
          pc_d    = redirect_pc;
          state_d = RUN;
        end else if (xfer) begin
          vld_d    = 1'b0;
          halted_d = 1'b1;
          state_d  = HALTED;
        end
      end

      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign slot.out_valid = vld_q;
  assign slot.opcode    = instr_q[OPC_MSB:OPC_LSB];
  assign slot.operand_a = instr_q[OPA_MSB:OPA_LSB];
  assign slot.operand_b = instr_q[OPB_MSB:OPB_LSB];
  assign slot.out_pc    = out_pc_q;
  assign halted         = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [7:0] fetch_cnt_q;
  logic [7:0] stall_cnt_q;

  // Saturating transfer/stall counters, cleared by reset or an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && (fetch_cnt_q != 8'hFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 8'd1;
      end
      if (stall && (stall_cnt_q != 8'hFF)) begin
        stall_cnt_q <= stall_cnt_q + 8'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  // start_ok and stall only feed the counters; keep them referenced
  logic unused_perf;
  assign unused_perf = start_ok ^ stall;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, corner sequences, randomized vs reference model.
// Latency: n/a.
// Backpressure: randomized out_ready.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [7:0]  fetch_count;
  logic [7:0]  stall_count;
`endif

  instr_fetch_unit_if #(.PC_W(4)) ifc ();

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .slot        (ifc),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] slot_instr();
    return {ifc.opcode, ifc.operand_a, ifc.operand_b};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  // Directed per-cycle vectors
  typedef struct {
    logic        start;
    logic        rdy;
    logic        redir;
    logic [3:0]  rpc;
    logic        e_vld;
    logic [11:0] e_instr;
    logic [3:0]  e_pc;
    logic        e_halt;
  } vec_t;
  vec_t tbl [19];

  // Reference model: program image, issue slot and run mode
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3;
  logic [11:0] m_mem [16];
  int          m_mode;
  int          m_pc;
  bit          m_vld;
  logic [11:0] m_instr;
  int          m_out_pc;
  bit          m_halted;
  int          m_fc;
  int          m_sc;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_vld = 0; m_instr = '0; m_out_pc = 0;
    m_halted = 0; m_fc = 0; m_sc = 0;
  endtask

  task automatic model_step(input bit s, input bit we, input logic [3:0] wa, input logic [11:0] wd,
                            input bit rdy, input bit rd, input logic [3:0] rp);
    bit xfer;
    bit stl;
    xfer = m_vld && rdy;
    stl  = m_vld && !rdy;
    if (xfer && m_fc < 255) m_fc++;
    if (stl && m_sc < 255) m_sc++;
    if (m_mode == M_IDLE || m_mode == M_HALT) begin
      if (we) m_mem[wa] = wd;
      if (s) begin
        m_pc = 0; m_halted = 0; m_mode = M_RUN; m_fc = 0; m_sc = 0;
      end
    end else if (rd) begin
      m_vld = 0; m_pc = int'(rp); m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!m_vld || xfer) begin
        m_instr = m_mem[m_pc]; m_out_pc = m_pc; m_vld = 1;
        if (m_instr[11:8] == 4'hF) m_mode = M_DRAIN;
        else m_pc = (m_pc + 1) % 16;
      end
    end else if (xfer) begin
      m_vld = 0; m_mode = M_HALT; m_halted = 1;
    end
  endtask

  task automatic rcyc(input bit s, input bit we, input logic [3:0] wa, input logic [11:0] wd,
                      input bit rdy, input bit rd, input logic [3:0] rp);
    start = s; prog_we = we; prog_addr = wa; prog_data = wd;
    ifc.out_ready = rdy; redirect = rd; redirect_pc = rp;
    model_step(s, we, wa, wd, rdy, rd, rp);
    tick();
    chk("rnd_valid", 32'(ifc.out_valid), 32'(m_vld));
    chk("rnd_halted", 32'(halted), 32'(m_halted));
    if (m_vld) begin
      chk("rnd_instr", 32'(slot_instr()), 32'(m_instr));
      chk("rnd_pc", 32'(ifc.out_pc), 32'(m_out_pc));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_fetch_cnt", 32'(fetch_count), 32'(m_fc));
    chk("rnd_stall_cnt", 32'(stall_count), 32'(m_sc));
`endif
  endtask

  initial begin
    int n;
    logic [11:0] d;
    bit s;

    // start, rdy, redir, rpc | valid, instr, pc, halted
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'h245, 4'h1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'hF00, 4'h2, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 12'h000, 4'h0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h123, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'h245, 4'h1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h245, 4'h1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 12'h000, 4'h0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 12'h3A7, 4'hA, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'h4B1, 4'hB, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 12'h000, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 12'hF00, 4'h2, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 4'h0, 1'b1};

    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    redirect = 1'b0; redirect_pc = '0; ifc.out_ready = 1'b0;
    #12;
    chk("reset_valid", 32'(ifc.out_valid), 0);
    chk("reset_fields", 32'({slot_instr(), ifc.out_pc}), 0);
    chk("reset_halted", 32'(halted), 0);
    rst_n = 1'b1;
    tick();

    wr(4'h0, 12'h123);
    wr(4'h1, 12'h245);
    wr(4'h2, 12'hF00);
    wr(4'hA, 12'h3A7);
    wr(4'hB, 12'h4B1);
    chk("idle_no_fetch", 32'(ifc.out_valid), 0);

    // Basic run to halt, backpressure, redirect while unaccepted, redirect with transfer
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start; ifc.out_ready = tbl[i].rdy;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      tick();
      start = 1'b0; redirect = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(ifc.out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].e_halt));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_instr", i), 32'(slot_instr()), 32'(tbl[i].e_instr));
        chk($sformatf("tbl%0d_pc", i), 32'(ifc.out_pc), 32'(tbl[i].e_pc));
      end
    end

    // Wrap: halt-free image, 17 accepted transfers must be pc 0..15,0
    for (int i = 2; i < 16; i++) wr(4'(i), {4'(i % 8), 4'(i), 4'(15 - i)});
    start = 1'b1; ifc.out_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 17; c++) begin
      // write attempt while running must not land
      prog_we = (c == 3); prog_addr = 4'h0; prog_data = 12'hEEE;
      if (ifc.out_valid) begin
        chk("wrap_pc", 32'(ifc.out_pc), 32'(n % 16));
        n++;
      end
      tick();
    end
    prog_we = 1'b0;
    chk("wrap_count", 32'(n), 17);

    // Asynchronous reset mid-run
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifc.out_valid), 0);
    chk("arst_fields", 32'({slot_instr(), ifc.out_pc}), 0);
    chk("arst_halted", 32'(halted), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(ifc.out_valid), 0);
    ifc.out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_valid", 32'(ifc.out_valid), 1);
    chk("restart_instr", 32'(slot_instr()), 32'h123);
    chk("restart_pc", 32'(ifc.out_pc), 0);

`ifdef FETCH_PERF_CNT_EN
    tick();
    tick();
    ifc.out_ready = 1'b1;
    tick(); tick(); tick();
    chk("perf_fetch", 32'(fetch_count), 3);
    chk("perf_stall", 32'(stall_count), 2);
`endif

    // Randomized phase against the reference model
    ifc.out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 16; i++) begin
      d = 12'($urandom);
      if ($urandom_range(0, 4) == 0) d[11:8] = 4'hF;
      rcyc(1'b0, 1'b1, 4'(i), d, 1'b0, 1'b0, 4'h0);
    end
    for (int i = 0; i < 1500; i++) begin
      if (m_mode == M_IDLE || m_mode == M_HALT) s = ($urandom_range(0, 3) == 0);
      else s = ($urandom_range(0, 19) == 0);
      d = 12'($urandom);
      if ($urandom_range(0, 4) == 0) d[11:8] = 4'hF;
      rcyc(s, ($urandom_range(0, 4) == 0), 4'($urandom), d,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream stage of the 4-bit processor core. It holds a small writable program memory and a program counter, and fetches 12-bit instructions. Each instruction is split into opcode, operand A and operand B, and passed to the execute stage (control unit / register file / ALU) over a valid/ready handshake. It also handles start, halt and branch redirect from downstream.

Parameters:
PC_W, 4, program-counter width; memory depth = 2**PC_W (16)
INSTR_W, 12, instruction width: [11:8] opcode, [7:4] operand A, [3:0] operand B
HALT_OPCODE, 4'hF, opcode that stops fetching

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins fetching at PC 0 from IDLE or HALTED
prog_we  input  1  program-memory write enable
prog_addr  input  PC_W  program-memory write address
prog_data  input  INSTR_W  program-memory write data
redirect  input  1  branch taken downstream; flush and refetch
redirect_pc  input  PC_W  new fetch address
out_valid  output  1  instruction slot holds a valid instruction
out_ready  input  1  downstream accepts the slot this cycle
opcode  output  4  instruction[11:8]
operand_a  output  4  instruction[7:4]
operand_b  output  4  instruction[3:0]
out_pc  output  PC_W  address the presented instruction was fetched from
halted  output  1  high in HALTED state

Behaviour:
- States: IDLE (after reset), RUN, DRAIN, HALTED.
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, pc=0, out_valid=0, halted=0;
  - opcode, operand_a, operand_b and out_pc = 0.
  - Program memory contents are not reset.
- Transfer = out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all output fields hold stable.
  - out_valid never drops without a transfer, except on a redirect flush or reset.
- Program memory:
  - Combinational read at pc; synchronous write.
  - prog_we is honoured only in IDLE or HALTED; it is ignored in RUN and DRAIN.
- IDLE or HALTED + start:
  - pc<=0, halted<=0, state->RUN.
  - If prog_we and start occur in the same cycle, the write completes before the first fetch.
- RUN:
  - When the slot is empty or transferring this cycle, the slot loads imem[pc], out_pc<=pc, out_valid<=1, pc<=pc+1.
  - Latency: start sampled at edge k; instruction 0 presented after edge k+1.
  - With out_ready held high, throughput is 1 instruction/cycle.
- PC wraps 2**PC_W-1 -> 0 without a flag.
- Halt:
  - A loaded instruction with opcode==HALT_OPCODE is still presented downstream. state->DRAIN and pc stops advancing.
  - In DRAIN, nothing further is fetched. On transfer of the halt instruction: out_valid<=0, state->HALTED, halted<=1.
- Redirect (RUN or DRAIN):
  - Flush: out_valid<=0, pc<=redirect_pc, state->RUN.
  - The first refetched instruction is presented one cycle later.
  - If redirect and transfer happen in the same cycle, the transfer counts; the flush affects only later fetches.
  - Redirect has priority over loading the next instruction.
  - Redirect in IDLE or HALTED is ignored.
- start while in RUN or DRAIN is ignored.
- If reset asserts mid-RUN, any in-flight instruction is discarded. After reset, start is required again.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: two extra outputs.
  - fetch_count (8 bits): increments on every transfer.
  - stall_count (8 bits): increments on every cycle with out_valid && !out_ready.
  - Both saturate at 8'hFF, clear on reset, and clear on start.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Package fetch_pkg:
  - state enum (IDLE, RUN, DRAIN, HALTED);
  - INSTR_W;
  - field-slice constants (OPC_MSB/LSB, OPA_MSB/LSB, OPB_MSB/LSB);
  - HALT_OPCODE default.
- One sub-module, fetch_imem: 2**PC_W x INSTR_W array with one write port and one combinational read port.

Test Plan:
- Load imem[0..2]={12'h123,12'h245,12'hF00}, pulse start, out_ready=1 -> opcode/operand_a/operand_b = 1/2/3, then 2/4/5, then F/0/0 on consecutive cycles; halted=1 one cycle after the halt transfer.
- Backpressure: hold out_ready=0 for 3 cycles while instruction 0 is valid -> outputs and out_pc=0 stable, pc not advanced; releasing gives 0,1,2 in order with none lost.
- Redirect while out_pc=1 is presented and unaccepted, redirect_pc=4'hA -> out_valid=0 next cycle, then out_pc=4'hA; the instruction at address 1 is never transferred.
- Wrap: imem has no HALT_OPCODE; run 17 transfers -> out_pc sequence 0..15,0.
- Reset mid-RUN (rst_n low between edges) -> out_valid and fields drop to 0 immediately; imem still holds the earlier program, and a re-start fetches 12'h123 again.
- With FETCH_PERF_CNT_EN: 3 transfers and 2 stall cycles -> fetch_count=3, stall_count=2; prog_we during RUN -> memory unchanged.
